// File: rtl/rv_pkg.sv
// Shared register-file widths and the writeback entry type used by the load
// response path.
package rv_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Bundle of the writeback stage's ALU, load, hazard-query and register-file
// write-port signals.
interface regfile_writeback_if;
  import rv_pkg::*;

  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  load_issue;
  logic [REG_ADDR_W-1:0] load_issue_rd;
  logic                  load_resp_valid;
  logic                  load_resp_ready;
  logic [REG_ADDR_W-1:0] load_resp_rd;
  logic [XLEN-1:0]       load_resp_data;
  logic [REG_ADDR_W-1:0] rs1_address;
  logic [REG_ADDR_W-1:0] rs2_address;
  logic                  hazard;
  logic                  en;
  logic [REG_ADDR_W-1:0] rd;
  logic [XLEN-1:0]       register_file_data;
  logic [NUM_REGS-1:0]   pending;

  modport master (
    output alu_valid, alu_rd, alu_data, load_issue, load_issue_rd,
           load_resp_valid, load_resp_rd, load_resp_data, rs1_address, rs2_address,
    input  load_resp_ready, hazard, en, rd, register_file_data, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, load_issue, load_issue_rd,
           load_resp_valid, load_resp_rd, load_resp_data, rs1_address, rs2_address,
    output load_resp_ready, hazard, en, rd, register_file_data, pending
  );

endinterface

// File: rtl/wb_fifo.sv
// Circular load-response buffer with extra-MSB pointers; no bypass, so an
// entry pushed this cycle is visible at the head from the next cycle.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  entry_t             mem [DEPTH];
  logic   [PTR_W-1:0] wr_ptr_q, rd_ptr_q;

  assign full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                    (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem[rd_ptr_q[IDX_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset: empty pointers mask stale contents.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: arbitrates ALU results over buffered load responses onto
// the register-file write port and tracks outstanding loads for hazard stalls.
module regfile_writeback
  import rv_pkg::*;
#(
  parameter int unsigned LOAD_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  regfile_writeback_if.slave bus
);

  wb_entry_t             push_entry, head;
  logic                  fifo_full, fifo_empty, push, pop;

  logic                  en_q, en_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       data_q, data_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign push_entry = '{rd: bus.load_resp_rd, data: bus.load_resp_data};
  assign push       = bus.load_resp_valid && !fifo_full;
  // ALU results cannot be stalled, so the FIFO only drains on ALU-idle cycles.
  assign pop        = !bus.alu_valid && !fifo_empty;

  wb_fifo #(
    .DEPTH   (LOAD_DEPTH),
    .entry_t (wb_entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    en_d      = 1'b0;
    rd_d      = rd_q;
    data_d    = data_q;
    pending_d = pending_q;

    if (bus.alu_valid) begin
      en_d   = (bus.alu_rd != '0);
      rd_d   = bus.alu_rd;
      data_d = bus.alu_data;
    end else if (pop) begin
      en_d   = (head.rd != '0);
      rd_d   = head.rd;
      data_d = head.data;
    end

    // Set is applied after clear so a re-issue to the popped register wins.
    if (pop) pending_d[head.rd] = 1'b0;
    if (bus.load_issue && (bus.load_issue_rd != '0)) pending_d[bus.load_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q      <= 1'b0;
      rd_q      <= '0;
      data_q    <= '0;
      pending_q <= '0;
    end else begin
      en_q      <= en_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
      pending_q <= pending_d;
    end
  end

  assign bus.load_resp_ready    = !fifo_full;
  assign bus.en                 = en_q;
  assign bus.rd                 = rd_q;
  assign bus.register_file_data = data_q;
  assign bus.pending            = pending_q;
  assign bus.hazard             = pending_q[bus.rs1_address] ||
                                  pending_q[bus.rs2_address] ||
                                  (bus.alu_valid && pending_q[bus.alu_rd]);

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed scenarios then random
// traffic, checked against a queue-based model of the writeback rules.
module tb_regfile_writeback;
  import rv_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_if bus();

  regfile_writeback #(.LOAD_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {logic [4:0] rd; logic [31:0] data; int c;} exp_t;
  typedef struct {logic [4:0] rd; logic [31:0] data;} ent_t;

  exp_t        expq[$];
  ent_t        lq[$];
  logic [4:0]  outq[$];
  logic [31:0] mp = '0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  bit          mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en && rst_n) begin
      if (bus.en) begin
        if (expq.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_write: got rd=%0d data=%h want no write", bus.rd,
                   bus.register_file_data);
        end else begin
          e = expq.pop_front();
          chk("wr_rd", 32'(bus.rd), 32'(e.rd));
          chk("wr_data", bus.register_file_data, e.data);
          chk("wr_cycle", cyc, e.c);
        end
      end else if (expq.size() > 0 && expq[0].c <= cyc) begin
        e = expq.pop_front();
        n_chk++;
        $display("FAIL missing_write: got en=0 want rd=%0d data=%h at cycle %0d", e.rd, e.data,
                 e.c);
      end
    end
  end

  // One clock of stimulus; the model advances to the state after the next edge.
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic li, input logic [4:0] lird,
                      input logic rv, input logic [4:0] rrd, input logic [31:0] rdat,
                      input logic [4:0] s1, input logic [4:0] s2);
    bit   acc;
    ent_t e;
    @(posedge clk);
    #1;
    chk("pending", bus.pending, mp);
    chk("ready", 32'(bus.load_resp_ready), 32'(lq.size() < DEPTH));
    bus.alu_valid = av;       bus.alu_rd = ard;              bus.alu_data = ad;
    bus.load_issue = li;      bus.load_issue_rd = lird;
    bus.load_resp_valid = rv; bus.load_resp_rd = rrd;        bus.load_resp_data = rdat;
    bus.rs1_address = s1;     bus.rs2_address = s2;
    #1;
    chk("hazard", 32'(bus.hazard), 32'(mp[s1] | mp[s2] | (av & mp[ard])));
    if (av) chk("alu_to_pending_reg", 32'(mp[ard]), 32'(0));
    acc = rv && (lq.size() < DEPTH);
    if (acc) chk("resp_to_clear_reg", 32'(mp[rrd]), 32'(1));
    if (av) begin
      if (ard != 0) expq.push_back('{ard, ad, cyc + 1});
    end else if (lq.size() > 0) begin
      e = lq.pop_front();
      mp[e.rd] = 1'b0;
      if (e.rd != 0) expq.push_back('{e.rd, e.data, cyc + 1});
    end
    if (acc) begin
      lq.push_back('{rrd, rdat});
      if (outq.size() > 0) void'(outq.pop_front());
    end
    if (li && lird != 0) begin
      mp[lird] = 1'b1;
      outq.push_back(lird);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drive_idle();
    bus.alu_valid = 0;  bus.alu_rd = 0;        bus.alu_data = 0;
    bus.load_issue = 0; bus.load_issue_rd = 0;
    bus.load_resp_valid = 0; bus.load_resp_rd = 0; bus.load_resp_data = 0;
    bus.rs1_address = 0; bus.rs2_address = 0;
  endtask

  initial begin
    logic       av, li, rv;
    logic [4:0] ard, lird, rrd;

    // Reset with random inputs toggling.
    drive_idle();
    repeat (5) begin
      @(negedge clk);
      bus.alu_valid = 1'($urandom);       bus.alu_rd = 5'($urandom);
      bus.alu_data = $urandom;            bus.load_issue = 1'($urandom);
      bus.load_issue_rd = 5'($urandom);   bus.load_resp_valid = 1'($urandom);
      bus.load_resp_rd = 5'($urandom);    bus.load_resp_data = $urandom;
    end
    chk("en_in_reset", 32'(bus.en), 32'(0));
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_en", 32'(bus.en), 32'(0));
    chk("rst_rd", 32'(bus.rd), 32'(0));
    chk("rst_data", bus.register_file_data, 32'(0));
    chk("rst_pending", bus.pending, 32'(0));
    chk("rst_ready", 32'(bus.load_resp_ready), 32'(1));
    mon_en = 1;

    // ALU path, then ALU write to x0.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Load flow for x7.
    step(0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step(0, 0, 0, 0, 0, 1, 7, 32'h1234, 0, 7);
    idle(3);

    // ALU and load response collide.
    step(0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    step(1, 3, 32'hA, 0, 0, 1, 9, 32'hB, 0, 0);
    idle(3);

    // Back-pressure under continuous ALU traffic.
    step(1, 1, 32'h100, 1, 10, 0, 0, 0, 0, 0);
    step(1, 1, 32'h101, 1, 11, 0, 0, 0, 0, 0);
    step(1, 1, 32'h102, 1, 12, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 2, 32'h200 + i, 0, 0, 1, outq[0], 32'hC0 + i, 10, 11);
    for (int i = 0; i < 4; i++) begin
      rv = outq.size() > 0;
      step(0, 0, 0, 0, 0, rv, rv ? outq[0] : 5'd0, 32'hD0 + i, 0, 0);
    end
    idle(3);

    // Pop of x4 races a new issue to x4; issue to x0 never marks pending.
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    step(1, 1, 32'h44, 0, 0, 1, 4, 32'h4444, 0, 0);
    step(0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 4, 0);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      av = $urandom_range(0, 2) != 0;
      ard = 5'($urandom);
      if (mp[ard]) av = 0;
      li = $urandom_range(0, 3) == 0;
      lird = 5'($urandom);
      if (mp[lird]) li = 0;
      rv = (outq.size() > 0) && ($urandom_range(0, 1) == 1);
      rrd = rv ? outq[0] : 5'($urandom);
      step(av, ard, $urandom, li, lird, rv, rrd, $urandom, 5'($urandom), 5'($urandom));
    end
    while (outq.size() > 0) step(0, 0, 0, 0, 0, 1, outq[0], $urandom, 0, 0);
    idle(4);

    // Reset while a write is on the port.
    step(1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_reset_en", 32'(bus.en), 32'(1));
    mon_en = 0;
    rst_n = 1'b0;
    #1;
    chk("async_reset_en", 32'(bus.en), 32'(0));
    chk("async_reset_pending", bus.pending, 32'(0));
    expq.delete();
    lq.delete();
    outq.delete();
    mp = '0;
    drive_idle();
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1;
    step(1, 8, 32'h88, 0, 0, 0, 0, 0, 0, 0);
    idle(3);

    chk("drain_empty", 32'(expq.size()), 32'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
